// File: rtl/instr_fetch.sv
// instr_fetch: fetches instructions from program memory into a 2-entry buffer for the decoder
module instr_fetch #(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [ADDR_W-1:0]  pc_val,
   input  logic               pc_wrap,
   output logic               pc_inc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               flush,
   input  logic               halt,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [INSTR_W-1:0] ir_data,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               wrapped
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_ACK, BUBBLE, DROP} state_t;
   state_t state;
   logic armed;
   logic [ADDR_W-1:0] lat_addr;
   logic [INSTR_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_addr [2];
   logic wp, rp;
   logic [1:0] count, count_nxt;
   logic push, pop;
   // A request is on the bus in FETCH, WAIT_ACK and DROP; FETCH presents the live counter value,
   // the waiting states hold the address latched when the request was issued.
   assign mem_req   = state inside {FETCH, WAIT_ACK, DROP};
   assign mem_addr  = state == FETCH ? pc_val : (state == WAIT_ACK || state == DROP) ? lat_addr : '0;
   // Data is kept only for a live (not dropped) request and never in a flush cycle.
   assign push      = mem_ack && !flush && (state == FETCH || state == WAIT_ACK);
   assign pc_inc    = push;
   assign ir_valid  = count != 2'd0;
   assign pop       = ir_valid && ir_ready && !flush;
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};
   assign ir_data   = fifo_data[rp];
   assign ir_pc     = fifo_addr[rp];
   // Instruction buffer: flush empties it and wins over a same-cycle pop.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wp        <= 1'b0;
         rp        <= 1'b0;
         count     <= 2'd0;
         fifo_data <= '{default: '0};
         fifo_addr <= '{default: '0};
      end else if (flush) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wp] <= mem_rdata;
            fifo_addr[wp] <= mem_addr;
            wp            <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count_nxt;
      end
   // Fetch sequencer; armed keeps the first request off the first edge after reset release.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state    <= IDLE;
         armed    <= 1'b0;
         lat_addr <= '0;
         wrapped  <= 1'b0;
      end else begin
         armed   <= 1'b1;
         wrapped <= flush ? 1'b0 : wrapped | (push & pc_wrap);
         if (state == FETCH) lat_addr <= pc_val;
         if (flush)
            state <= (mem_req && !mem_ack) ? DROP : BUBBLE;
         else
            case (state)
               IDLE:     state <= (armed && !halt && count < 2'd2) ? FETCH : IDLE;
               FETCH:    state <= !mem_ack ? WAIT_ACK : (!halt && count_nxt < 2'd2) ? FETCH : IDLE;
               WAIT_ACK: state <= mem_ack ? IDLE : WAIT_ACK;
               DROP:     state <= mem_ack ? BUBBLE : DROP;
               default:  state <= IDLE;
            endcase
      end
endmodule
